conv_stream: RTL

- Streaming 2-D convolution engine, the parametrised successor of the fixed 32x32 / 3x3 array convolution.
- Accepts one signed pixel per cycle in raster order over a valid/ready handshake and holds K-1 image rows in line buffers.
- Applies a KxK signed fixed-point kernel plus bias and emits the "valid" (unpadded) output image, also in raster order, with backpressure.
- Sits between the image source and the downstream pooling/activation stages.

---
 rtl/conv_stream.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/conv_stream.sv
// conv_stream: streaming KxK 2-D convolution over an IMG_W x IMG_H signed image.
//
// Pixels arrive in raster order on a valid/ready handshake. K-1 previous rows
// live in line buffers. Each accepted pixel whose position allows a full window
// produces one output: the KxK dot product with a signed fixed-point kernel.
// The sum is shifted right by FRAC, the bias is added, and the result is
// saturated to DATA_W bits. Only the unpadded (valid) output image is emitted,
// in raster order.
//
// Ports:
//   clk, rst               clock, synchronous active-high reset
//   in_valid/in_ready      input pixel handshake, in_data = signed pixel
//   kernel, bias           weights (index r*K+c at bits (r*K+c)*DATA_W) and
//                          bias, both sampled when pixel (0,0) of a frame is accepted
//   out_valid/out_ready    output handshake, out_data = signed result
//   out_last               flags the final output pixel of a frame
//   frame_busy             high from pixel (0,0) until the last pixel is accepted
//
// Optional build macro: CONV_STREAM_RELU_EN. When defined, negative results
// are clamped to 0 after saturation, and the latency does not change.
module conv_stream #(
  parameter int IMG_W  = 32,
  parameter int IMG_H  = 32,
  parameter int DATA_W = 16,
  parameter int K      = 3,
  parameter int FRAC   = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_W-1:0]     in_data,
  input  logic [K*K*DATA_W-1:0] kernel,
  input  logic [DATA_W-1:0]     bias,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_W-1:0]     out_data,
  output logic                  out_last,
  output logic                  frame_busy
);
  localparam int CW    = $clog2(IMG_W);
  localparam int RW    = $clog2(IMG_H);
  localparam int NT    = K * K;
  localparam int PW    = 2 * DATA_W;
  // One spare bit on top of the minimum keeps the sum, the shift and the bias
  // add free of overflow, even at the extreme corners.
  localparam int ACC_W = PW + $clog2(NT) + 1;
  localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

  logic                          adv, accept, last_px, win_ok;
  logic [CW-1:0]                 col_q, col_d;
  logic [RW-1:0]                 row_q, row_d;
  logic                          frame_busy_q, frame_busy_d;
  logic [NT*DATA_W-1:0]          kern_q;
  logic [DATA_W-1:0]             bias_q;
  logic [K-1:0][DATA_W-1:0]      col_vec;
  logic [K-1:0][K-1:0][DATA_W-1:0] win_q;
  logic                          s1_v_q, s1_last_q;
  logic signed [PW-1:0]          prod_q [NT];
  logic signed [DATA_W-1:0]      bias_s2_q;
  logic                          s2_v_q, s2_last_q;
  logic                          out_valid_q, out_last_q;
  logic [DATA_W-1:0]             out_data_q, out_data_d;
  logic signed [ACC_W-1:0]       acc_sum, acc_shr, acc_biased;

  // The whole pipeline moves as one unit. It freezes only when a finished
  // result is waiting for the downstream stage to take it.
  assign adv      = !out_valid_q || out_ready;
  assign in_ready = adv;
  assign accept   = in_valid && adv;
  assign last_px  = (col_q == CW'(IMG_W-1)) && (row_q == RW'(IMG_H-1));
  assign win_ok   = (row_q >= RW'(K-1)) && (col_q >= CW'(K-1));

  // Raster position counters. They wrap straight into the next frame.
  always_comb begin
    col_d        = col_q;
    row_d        = row_q;
    frame_busy_d = frame_busy_q;
    if (accept) begin
      frame_busy_d = !last_px;
      if (col_q == CW'(IMG_W-1)) begin
        col_d = '0;
        row_d = (row_q == RW'(IMG_H-1)) ? '0 : row_q + RW'(1);
      end else begin
        col_d = col_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      col_q        <= '0;
      row_q        <= '0;
      frame_busy_q <= 1'b0;
    end else begin
      col_q        <= col_d;
      row_q        <= row_d;
      frame_busy_q <= frame_busy_d;
    end
  end

  // Kernel and bias are frozen for the whole frame.
  always_ff @(posedge clk) begin
    if (accept && (col_q == '0) && (row_q == '0)) begin
      kern_q <= kernel;
      bias_q <= bias;
    end
  end

  // Line buffers. Buffer 0 holds the oldest row. Every accept shifts the
  // current column up by one row, so col_vec[0..K-1] is the window column,
  // ordered from the top row down to the incoming pixel.
  assign col_vec[K-1] = in_data;
  for (genvar gi = 0; gi < K-1; gi++) begin : g_lb
    logic [DATA_W-1:0] mem [IMG_W];
    assign col_vec[gi] = mem[col_q];
    always_ff @(posedge clk) begin
      if (accept) mem[col_q] <= col_vec[gi+1];
    end
  end

  // S1: the window register. Column K-1 is the newest column.
  always_ff @(posedge clk) begin
    if (accept) begin
      for (int r = 0; r < K; r++) begin
        for (int c = 0; c < K-1; c++) win_q[r][c] <= win_q[r][c+1];
        win_q[r][K-1] <= col_vec[r];
      end
    end
  end

  // S2: full-width signed products. S2 always advances on the same edge that
  // could accept the next frame's (0,0), so it still sees the old kernel.
  // The bias travels with the products for the same reason.
  for (genvar gi = 0; gi < NT; gi++) begin : g_mul
    logic signed [DATA_W-1:0] px_s, w_s;
    assign px_s = win_q[gi/K][gi%K];
    assign w_s  = kern_q[gi*DATA_W +: DATA_W];
    always_ff @(posedge clk) begin
      if (adv) prod_q[gi] <= PW'(px_s) * PW'(w_s);
    end
  end

  always_ff @(posedge clk) begin
    if (adv) bias_s2_q <= bias_q;
  end

  // S3: sum, scale, bias, saturate.
  always_comb begin
    acc_sum = '0;
    for (int i = 0; i < NT; i++) acc_sum = acc_sum + ACC_W'(prod_q[i]);
    acc_shr    = acc_sum >>> FRAC;
    acc_biased = acc_shr + ACC_W'(bias_s2_q);
    if (acc_biased > SAT_MAX)      out_data_d = {1'b0, {(DATA_W-1){1'b1}}};
    else if (acc_biased < SAT_MIN) out_data_d = {1'b1, {(DATA_W-1){1'b0}}};
    else                           out_data_d = acc_biased[DATA_W-1:0];
`ifdef CONV_STREAM_RELU_EN
    if (out_data_d[DATA_W-1]) out_data_d = '0;
`endif
  end

  // Valid and last bits that follow the data through the pipeline.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_v_q      <= 1'b0;
      s1_last_q   <= 1'b0;
      s2_v_q      <= 1'b0;
      s2_last_q   <= 1'b0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_data_q  <= '0;
    end else if (adv) begin
      s1_v_q      <= accept && win_ok;
      s1_last_q   <= accept && last_px;
      s2_v_q      <= s1_v_q;
      s2_last_q   <= s1_last_q;
      out_valid_q <= s2_v_q;
      out_last_q  <= s2_v_q && s2_last_q;
      if (s2_v_q) out_data_q <= out_data_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;
  assign out_last   = out_last_q;
  assign frame_busy = frame_busy_q;

endmodule
